// File: rtl/spi_flash_rd_ctrl.sv
// SPI NOR flash read sequencer: issues one READ (0x03) + address per request, clocks in
// eight bytes in SPI mode 0 and returns them little-endian on a valid/ready channel.
module spi_flash_rd_ctrl #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_IDLE = 4,
    parameter int unsigned ADDR_W  = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_cs,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_data,
    output logic              spi_flash_clk,
    output logic [1:0]        spi_flash_cs,
    output logic              spi_flash_mosi,
    input  logic              spi_flash_miso
);
    localparam int unsigned HDR_W  = 8 + ADDR_W;
    localparam int unsigned NBITS  = HDR_W + 64;
    localparam int unsigned BIT_W  = $clog2(NBITS + 1);
    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDLE_W = (CS_IDLE > 0) ? $clog2(CS_IDLE + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(NBITS - 1);
    localparam logic [IDLE_W-1:0] IDLE_INIT = IDLE_W'(CS_IDLE);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    state_t            state, state_d;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_d;
    logic [DIV_W-1:0]  div_cnt, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [HDR_W-1:0]  tx, tx_d;
    logic [63:0]       rx, rx_d, rx_le;
    logic              sck_d, req_ready_d, rsp_valid_d;
    logic [1:0]        cs_d;
    logic [63:0]       rsp_data_d;
    logic              accept, phase_end, shift_done;

    assign accept         = (state == IDLE) && req_valid && req_ready;
    assign phase_end      = (div_cnt == DIV_LAST);
    assign shift_done     = (state == SHIFT) && spi_flash_clk && phase_end && (bit_cnt == LAST_BIT);
    // TX drains to zero during the data phase, so MOSI idles low without extra muxing.
    assign spi_flash_mosi = tx[HDR_W-1];

    // First byte on the wire sits in rx[63:56]; it belongs in the lowest response byte.
    always_comb begin
        rx_le = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            rx_le[8*k +: 8] = rx[56 - 8*k +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (accept)     state_d = SHIFT;
            SHIFT:   if (shift_done) state_d = RESP;
            RESP:    if (rsp_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        idle_cnt_d  = (idle_cnt != '0) ? idle_cnt - IDLE_W'(1) : '0;
        div_cnt_d   = div_cnt;
        bit_cnt_d   = bit_cnt;
        tx_d        = tx;
        rx_d        = rx;
        sck_d       = spi_flash_clk;
        cs_d        = spi_flash_cs;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    tx_d      = {8'h03, req_addr};
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    sck_d     = 1'b0;
                    cs_d      = req_cs ? 2'b01 : 2'b10;
                end
            end
            SHIFT: begin
                if (!phase_end) begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                end else begin
                    div_cnt_d = '0;
                    if (!spi_flash_clk) begin
                        sck_d = 1'b1;
                        rx_d  = {rx[62:0], spi_flash_miso};
                    end else begin
                        sck_d     = 1'b0;
                        tx_d      = {tx[HDR_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            cs_d        = '1;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = rx_le;
                            idle_cnt_d  = IDLE_INIT;
                        end
                    end
                end
            end
            RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
        req_ready_d = (state_d == IDLE) && (idle_cnt_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt      <= IDLE_INIT;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            tx            <= '0;
            rx            <= '0;
            spi_flash_clk <= 1'b0;
            spi_flash_cs  <= '1;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
        end else begin
            idle_cnt      <= idle_cnt_d;
            div_cnt       <= div_cnt_d;
            bit_cnt       <= bit_cnt_d;
            tx            <= tx_d;
            rx            <= rx_d;
            spi_flash_clk <= sck_d;
            spi_flash_cs  <= cs_d;
            req_ready     <= req_ready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_data      <= rsp_data_d;
        end
    end

endmodule
